fetch_hazard_controller: RTL and testbench

- Sequences the instruction fetch stage of the 5-stage RISC-V pipeline.
- Drives the fetch stage's pc_write, IF_ID_write, IF_flush and pc_src from ID/EX/MEM hazard information and the ID-stage branch compare (br_eq).
- Inserts load-use and branch-operand stalls, flushes on taken branches, and provides a debug halt/single-step mechanism with saturating stall/flush performance counters.
- Sits beside the decode stage, feeding the fetch stage and the ID/EX bubble mux.

---
 rtl/fetch_hazard_controller.sv | 185 ++++++++++++++++++
 tb/tb_fetch_hazard_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_hazard_controller.sv
// Fetch-stage sequencer for the 5-stage RISC-V pipeline.
// It takes ID/EX/MEM hazard information and the ID-stage branch compare,
// and from them drives the PC / IF-ID enables, the taken-branch flush and
// redirect, and the ID/EX bubble. It also handles debug halt and
// single-step, and keeps saturating stall/flush performance counters.
module fetch_hazard_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             ID_uses_rs2,
  input  logic             ID_branch,
  input  logic             br_eq,
  input  logic             ID_EX_reg_write,
  input  logic             ID_EX_mem_read,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_MEM_mem_read,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             halt_req,
  input  logic             step,
  input  logic             resume,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_flush,
  output logic             pc_src,
  output logic             ID_EX_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned NEED_W = 2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2,
    S_STEP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NEED_W-1:0]  scnt_q, scnt_d;
  logic               ret_halt_q, ret_halt_d;
  logic               halted_q;
  logic [CNT_W-1:0]   stall_count_q;
  logic [CNT_W-1:0]   flush_count_q;

  logic               m_ex;
  logic               m_mem;
  logic [NEED_W-1:0]  need;
  logic               stall_inc;
  logic               flush_inc;

  // Source-register match against EX and MEM destinations (x0 never matches)
  always_comb begin
    m_ex  = (ID_EX_rd != REG_W'(0)) &&
            ((ID_EX_rd == IF_ID_rs1) || (ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));
    m_mem = (EX_MEM_rd != REG_W'(0)) &&
            ((EX_MEM_rd == IF_ID_rs1) || (EX_MEM_rd == IF_ID_rs2 && ID_uses_rs2));
  end

  // Stall cycles the ID instruction still needs; the first matching rule wins
  always_comb begin
    need = NEED_W'(0);
    if (ID_branch && ID_EX_mem_read && m_ex) begin
      need = NEED_W'(2);
    end else if (ID_branch && ID_EX_reg_write && m_ex) begin
      need = NEED_W'(1);
    end else if (ID_branch && EX_MEM_mem_read && m_mem) begin
      need = NEED_W'(1);
    end else if (!ID_branch && ID_EX_mem_read && m_ex) begin
      need = NEED_W'(1);
    end
  end

  // Next-state and fetch-control outputs; reset forces a flushing freeze
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    ret_halt_d   = ret_halt_q;
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    IF_flush     = 1'b0;
    pc_src       = 1'b0;
    ID_EX_bubble = 1'b1;

    case (state_q)
      S_RUN, S_STEP: begin
        if (need != NEED_W'(0)) begin
          // A stepped hazard consumes the step; a 2-cycle one returns to HALT
          scnt_d = need - NEED_W'(1);
          if (need == NEED_W'(2)) begin
            state_d    = S_STALL;
            ret_halt_d = (state_q == S_STEP);
          end else begin
            state_d = (state_q == S_STEP) ? S_HALT : S_RUN;
          end
        end else begin
          pc_write     = 1'b1;
          IF_ID_write  = 1'b1;
          ID_EX_bubble = 1'b0;
          if (ID_branch && br_eq) begin
            pc_src   = 1'b1;
            IF_flush = 1'b1;
          end
          if (state_q == S_STEP || halt_req) begin
            state_d = S_HALT;
          end
        end
      end

      S_STALL: begin
        if (scnt_q != NEED_W'(0)) begin
          scnt_d = scnt_q - NEED_W'(1);
        end
        state_d    = ret_halt_q ? S_HALT : S_RUN;
        ret_halt_d = 1'b0;
      end

      S_HALT: begin
        if (resume) begin
          state_d = S_RUN;
        end else if (step) begin
          state_d = S_STEP;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    if (reset) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_flush     = 1'b1;
      pc_src       = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  // Counter increment qualifiers (HALT and reset cycles are not counted)
  always_comb begin
    stall_inc = !reset && (state_q != S_HALT) && !pc_write;
    flush_inc = !reset && pc_src;
  end

  // State, stall sequencing and halt status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      scnt_q     <= NEED_W'(0);
      ret_halt_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      ret_halt_q <= ret_halt_d;
      halted_q   <= (state_d == S_HALT);
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= CNT_W'(0);
      flush_count_q <= CNT_W'(0);
    end else begin
      if (stall_inc && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
      if (flush_inc && (flush_count_q != {CNT_W{1'b1}})) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed testbench for fetch_hazard_controller.
module tb_fetch_hazard_controller;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic [4:0]       IF_ID_rs1;
  logic [4:0]       IF_ID_rs2;
  logic             ID_uses_rs2;
  logic             ID_branch;
  logic             br_eq;
  logic             ID_EX_reg_write;
  logic             ID_EX_mem_read;
  logic [4:0]       ID_EX_rd;
  logic             EX_MEM_mem_read;
  logic [4:0]       EX_MEM_rd;
  logic             halt_req;
  logic             step;
  logic             resume;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_flush;
  logic             pc_src;
  logic             ID_EX_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  int unsigned n_tests;
  int unsigned n_fail;

  // {pc_write, IF_ID_write, IF_flush, pc_src, ID_EX_bubble}
  logic [4:0] outs;
  assign outs = {pc_write, IF_ID_write, IF_flush, pc_src, ID_EX_bubble};

  localparam logic [4:0] O_STALL = 5'b00001;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_TAKEN = 5'b11110;
  localparam logic [4:0] O_RST   = 5'b00101;

  fetch_hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_rs1       (IF_ID_rs1),
    .IF_ID_rs2       (IF_ID_rs2),
    .ID_uses_rs2     (ID_uses_rs2),
    .ID_branch       (ID_branch),
    .br_eq           (br_eq),
    .ID_EX_reg_write (ID_EX_reg_write),
    .ID_EX_mem_read  (ID_EX_mem_read),
    .ID_EX_rd        (ID_EX_rd),
    .EX_MEM_mem_read (EX_MEM_mem_read),
    .EX_MEM_rd       (EX_MEM_rd),
    .halt_req        (halt_req),
    .step            (step),
    .resume          (resume),
    .pc_write        (pc_write),
    .IF_ID_write     (IF_ID_write),
    .IF_flush        (IF_flush),
    .pc_src          (pc_src),
    .ID_EX_bubble    (ID_EX_bubble),
    .halted          (halted),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    IF_ID_rs1       = 5'd0;
    IF_ID_rs2       = 5'd0;
    ID_uses_rs2     = 1'b0;
    ID_branch       = 1'b0;
    br_eq           = 1'b0;
    ID_EX_reg_write = 1'b0;
    ID_EX_mem_read  = 1'b0;
    ID_EX_rd        = 5'd0;
    EX_MEM_mem_read = 1'b0;
    EX_MEM_rd       = 5'd0;
    halt_req        = 1'b0;
    step            = 1'b0;
    resume          = 1'b0;
  endtask

  // Advance one clock; returns 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs
  task automatic settle();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr();
    reset = 1'b1;
    settle();
    check("reset_outs", 32'(outs), 32'(O_RST));
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_stall_cnt", 32'(stall_count), 32'd0);
    check("reset_flush_cnt", 32'(flush_count), 32'd0);
    check("reset_run_outs", 32'(outs), 32'(O_RUN));

    // 1: lw x14 in EX, ID add x5,x19,x14 -> one stall cycle
    clr();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd14;
    IF_ID_rs1 = 5'd19; IF_ID_rs2 = 5'd14; ID_uses_rs2 = 1'b1;
    settle();
    check("t1_loaduse_stall", 32'(outs), 32'(O_STALL));
    tick();
    ID_EX_mem_read = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_rd = 5'd0;
    EX_MEM_mem_read = 1'b1; EX_MEM_rd = 5'd14;
    settle();
    check("t1_run_after", 32'(outs), 32'(O_RUN));
    check("t1_stall_cnt", 32'(stall_count), 32'd1);
    tick();

    // 2: lw x14 in EX, ID beq x1,x14 -> two stall cycles then taken
    clr();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd14;
    ID_branch = 1'b1; IF_ID_rs1 = 5'd1; IF_ID_rs2 = 5'd14; ID_uses_rs2 = 1'b1;
    br_eq = 1'b1;
    settle();
    check("t2_stall1", 32'(outs), 32'(O_STALL));
    tick();
    ID_EX_mem_read = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_rd = 5'd0;
    EX_MEM_mem_read = 1'b1; EX_MEM_rd = 5'd14;
    settle();
    check("t2_stall2", 32'(outs), 32'(O_STALL));
    tick();
    EX_MEM_mem_read = 1'b0; EX_MEM_rd = 5'd0;
    settle();
    check("t2_taken", 32'(outs), 32'(O_TAKEN));
    tick();
    check("t2_stall_cnt", 32'(stall_count), 32'd3);
    check("t2_flush_cnt", 32'(flush_count), 32'd1);

    // 3: beq x1,x10 with no hazard, taken then not taken
    clr();
    ID_branch = 1'b1; IF_ID_rs1 = 5'd1; IF_ID_rs2 = 5'd10; ID_uses_rs2 = 1'b1;
    br_eq = 1'b1;
    settle();
    check("t3_taken", 32'(outs), 32'(O_TAKEN));
    tick();
    br_eq = 1'b0;
    settle();
    check("t3_not_taken", 32'(outs), 32'(O_RUN));
    tick();
    check("t3_flush_cnt", 32'(flush_count), 32'd2);

    // 4: x0 never hazards; ALU result in EX forwards to a non-branch
    clr();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd0;
    ID_uses_rs2 = 1'b1;
    settle();
    check("t4_x0_nostall", 32'(outs), 32'(O_RUN));
    tick();
    clr();
    ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd8; IF_ID_rs1 = 5'd8;
    settle();
    check("t4_fwd_nostall", 32'(outs), 32'(O_RUN));
    tick();
    // rs2 match ignored when ID does not read rs2
    clr();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd9;
    IF_ID_rs1 = 5'd3; IF_ID_rs2 = 5'd9; ID_uses_rs2 = 1'b0;
    settle();
    check("t4_rs2_unused", 32'(outs), 32'(O_RUN));
    tick();
    // branch reading an ALU result in EX: one stall
    clr();
    ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd8;
    ID_branch = 1'b1; IF_ID_rs1 = 5'd8; IF_ID_rs2 = 5'd2; ID_uses_rs2 = 1'b1;
    settle();
    check("t4_br_ex_stall", 32'(outs), 32'(O_STALL));
    tick();
    // branch reading a load in MEM: one stall
    clr();
    EX_MEM_mem_read = 1'b1; EX_MEM_rd = 5'd6;
    ID_branch = 1'b1; IF_ID_rs1 = 5'd2; IF_ID_rs2 = 5'd6; ID_uses_rs2 = 1'b1;
    settle();
    check("t4_br_mem_stall", 32'(outs), 32'(O_STALL));
    tick();
    check("t4_stall_cnt", 32'(stall_count), 32'd5);

    // 5: halt with a taken branch in the same cycle, then step/resume
    clr();
    halt_req = 1'b1;
    ID_branch = 1'b1; IF_ID_rs1 = 5'd1; IF_ID_rs2 = 5'd1; br_eq = 1'b1;
    settle();
    check("t5_halt_taken", 32'(outs), 32'(O_TAKEN));
    tick();
    clr();
    halt_req = 1'b1;
    settle();
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_halt_outs", 32'(outs), 32'(O_STALL));
    check("t5_flush_cnt", 32'(flush_count), 32'd3);
    tick();
    check("t5_halt_hold", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      settle();
      check("t5_pre_step_outs", 32'(outs), 32'(O_STALL));
      tick();
      step = 1'b0;
      settle();
      check("t5_step_run", 32'(outs), 32'(O_RUN));
      check("t5_step_halted", 32'(halted), 32'd0);
      tick();
      check("t5_back_halted", 32'(halted), 32'd1);
    end
    check("t5_halt_stall_cnt", 32'(stall_count), 32'd5);
    // step into a 2-cycle hazard: STEP stall, STALL, back to HALT
    step = 1'b1;
    tick();
    step = 1'b0;
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd14;
    ID_branch = 1'b1; IF_ID_rs1 = 5'd14;
    settle();
    check("t5_step_need2", 32'(outs), 32'(O_STALL));
    tick();
    check("t5_in_stall", 32'(halted), 32'd0);
    tick();
    check("t5_stall_ret_halt", 32'(halted), 32'd1);
    check("t5_step_stall_cnt", 32'(stall_count), 32'd7);
    // resume beats step; halt_req dropped with it
    clr();
    resume = 1'b1; step = 1'b1;
    tick();
    clr();
    settle();
    check("t5_resumed", 32'(halted), 32'd0);
    check("t5_resume_run", 32'(outs), 32'(O_RUN));
    tick();
    check("t5_stay_run", 32'(halted), 32'd0);

    // 6: reset during the second stall cycle, then saturation
    clr();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_rd = 5'd14;
    ID_branch = 1'b1; IF_ID_rs1 = 5'd14;
    tick();
    reset = 1'b1;
    settle();
    check("t6_reset_outs", 32'(outs), 32'(O_RST));
    tick();
    reset = 1'b0;
    clr();
    ID_branch = 1'b1; br_eq = 1'b1;
    settle();
    check("t6_post_run_taken", 32'(outs), 32'(O_TAKEN));
    check("t6_post_stall_cnt", 32'(stall_count), 32'd0);
    check("t6_post_flush_cnt", 32'(flush_count), 32'd0);
    tick();
    check("t6_flush_cnt", 32'(flush_count), 32'd1);
    clr();
    ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd4; IF_ID_rs1 = 5'd4;
    for (int i = 0; i < 65534; i++) tick();
    check("t6_cnt_fffe", 32'(stall_count), 32'h0000_FFFE);
    tick();
    check("t6_cnt_ffff", 32'(stall_count), 32'h0000_FFFF);
    tick();
    check("t6_cnt_sat", 32'(stall_count), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
